// File: rtl/sram_cycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_cycle_ctrl_if : CPU/SRAM-side signal bundle for sram_cycle_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sram_cycle_ctrl_if;
    logic        i_sram_window;
    logic        i_rw;
    logic [15:0] i_addr;
    logic [7:0]  i_cpu_data;
    logic [7:0]  i_sram_data;
    logic [7:0]  o_cpu_data;
    logic        o_cpu_data_oe;
    logic [7:0]  o_sram_data;
    logic        o_sram_data_oe;
    logic        o_sram_ce_n;
    logic        o_sram_oe_n;
    logic        o_sram_we_n;
    logic        o_busy;
    logic        o_err_short;

    modport master (
        output i_sram_window, i_rw, i_addr, i_cpu_data, i_sram_data,
        input  o_cpu_data, o_cpu_data_oe, o_sram_data, o_sram_data_oe,
        input  o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_busy, o_err_short
    );

    modport slave (
        input  i_sram_window, i_rw, i_addr, i_cpu_data, i_sram_data,
        output o_cpu_data, o_cpu_data_oe, o_sram_data, o_sram_data_oe,
        output o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_busy, o_err_short
    );
endinterface
`default_nettype wire

// File: rtl/sram_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_cycle_ctrl : one SRAM bus cycle per registered access window     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sram_cycle_ctrl #(
    parameter logic [15:0] SRAM_BASE = 16'h0000,
    parameter logic [15:0] SRAM_MASK = 16'h8000,
    parameter int          RD_SETUP  = 5,
    parameter int          WR_DELAY  = 3,
    parameter int          HOLD      = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    sram_cycle_ctrl_if.slave  bus
);
    localparam int MAXP  = (RD_SETUP > WR_DELAY) ? ((RD_SETUP > HOLD) ? RD_SETUP : HOLD)
                                                 : ((WR_DELAY > HOLD) ? WR_DELAY : HOLD);
    localparam int CNT_W = (MAXP < 2) ? 1 : $clog2(MAXP);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        RD_DRIVE  = 3'd2,
        RD_HOLD   = 3'd3,
        WR_ACTIVE = 3'd4,
        WR_HOLD   = 3'd5,
        WAIT_LOW  = 3'd6
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               window_prev_q;
    logic [7:0]         cpu_data_q;
    logic               cpu_data_oe_q;
    logic [7:0]         sram_data_q;
    logic               sram_data_oe_q;
    logic               ce_n_q;
    logic               oe_n_q;
    logic               we_n_q;
    logic               busy_q;
    logic               err_short_q;

    logic rise;
    logic hit;
    logic win;

    assign win  = bus.i_sram_window;
    assign rise = win & ~window_prev_q;
    assign hit  = ((bus.i_addr & SRAM_MASK) == (SRAM_BASE & SRAM_MASK));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            window_prev_q  <= 1'b1;  // a window already high at release must not start a cycle
            cpu_data_q     <= 8'h00;
            cpu_data_oe_q  <= 1'b0;
            sram_data_q    <= 8'h00;
            sram_data_oe_q <= 1'b0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            busy_q         <= 1'b0;
            err_short_q    <= 1'b0;
        end else begin
            window_prev_q <= win;
            err_short_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        busy_q <= 1'b1;
                        if (!hit) begin
                            state_q <= WAIT_LOW;
                        end else if (bus.i_rw) begin
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b0;
                            cnt_q   <= CNT_W'(RD_SETUP - 1);
                            state_q <= RD_ACCESS;
                        end else begin
                            ce_n_q         <= 1'b0;
                            sram_data_oe_q <= 1'b1;
                            sram_data_q    <= bus.i_cpu_data;
                            cnt_q          <= CNT_W'(WR_DELAY - 1);
                            state_q        <= WR_ACTIVE;
                        end
                    end
                end
                RD_ACCESS: begin
                    if (!win) begin
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        err_short_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        cpu_data_q    <= bus.i_sram_data;
                        cpu_data_oe_q <= 1'b1;
                        state_q       <= RD_DRIVE;
                    end
                end
                RD_DRIVE: begin
                    if (!win) begin
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        cnt_q   <= CNT_W'(HOLD - 1);
                        state_q <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    // Rises seen here are deliberately dropped, not queued.
                    if (cnt_q == '0) begin
                        cpu_data_oe_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WR_ACTIVE: begin
                    if (!win) begin
                        we_n_q      <= 1'b1;
                        err_short_q <= we_n_q;
                        state_q     <= WR_HOLD;
                    end else begin
                        sram_data_q <= bus.i_cpu_data;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            we_n_q <= 1'b0;
                        end
                    end
                end
                WR_HOLD: begin
                    ce_n_q         <= 1'b1;
                    sram_data_oe_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                WAIT_LOW: begin
                    if (!win) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ce_n_q         <= 1'b1;
                    oe_n_q         <= 1'b1;
                    we_n_q         <= 1'b1;
                    cpu_data_oe_q  <= 1'b0;
                    sram_data_oe_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_cpu_data     = cpu_data_q;
    assign bus.o_cpu_data_oe  = cpu_data_oe_q;
    assign bus.o_sram_data    = sram_data_q;
    assign bus.o_sram_data_oe = sram_data_oe_q;
    assign bus.o_sram_ce_n    = ce_n_q;
    assign bus.o_sram_oe_n    = oe_n_q;
    assign bus.o_sram_we_n    = we_n_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_err_short    = err_short_q;
endmodule
`default_nettype wire

// File: tb/tb_sram_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_cycle_ctrl : directed self-checking bench for sram_cycle_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sram_cycle_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sram_cycle_ctrl_if bus ();

    sram_cycle_ctrl dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each tick lands 1ns after a rising edge, so checks read settled registers.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.i_sram_window = 1'b0;
        bus.i_rw          = 1'b1;
        bus.i_addr        = 16'h0000;
        bus.i_cpu_data    = 8'h00;
        bus.i_sram_data   = 8'h00;
        tick(2);

        chk1("rst_ce_n",    bus.o_sram_ce_n,    1'b1);
        chk1("rst_oe_n",    bus.o_sram_oe_n,    1'b1);
        chk1("rst_we_n",    bus.o_sram_we_n,    1'b1);
        chk1("rst_cpu_oe",  bus.o_cpu_data_oe,  1'b0);
        chk1("rst_sram_oe", bus.o_sram_data_oe, 1'b0);
        chk1("rst_busy",    bus.o_busy,         1'b0);
        chk8("rst_cpu_dat", bus.o_cpu_data,     8'h00);
        rst_n = 1'b1;
        tick(2);

        // Read 0x1234, window high 12 cycles
        bus.i_addr = 16'h1234; bus.i_rw = 1'b1; bus.i_sram_data = 8'hA5;
        bus.i_sram_window = 1'b1;
        tick(1);
        chk1("rd_k_ce_n",   bus.o_sram_ce_n,   1'b0);
        chk1("rd_k_oe_n",   bus.o_sram_oe_n,   1'b0);
        chk1("rd_k_busy",   bus.o_busy,        1'b1);
        tick(4);
        chk1("rd_k4_cpuoe", bus.o_cpu_data_oe, 1'b0);
        tick(1);
        chk1("rd_k5_cpuoe", bus.o_cpu_data_oe, 1'b1);
        chk8("rd_k5_data",  bus.o_cpu_data,    8'hA5);
        chk1("rd_k5_we_n",  bus.o_sram_we_n,   1'b1);
        tick(6);
        bus.i_sram_window = 1'b0;
        tick(1);
        chk1("rd_k12_ce_n",  bus.o_sram_ce_n,   1'b1);
        chk1("rd_k12_oe_n",  bus.o_sram_oe_n,   1'b1);
        chk1("rd_k12_cpuoe", bus.o_cpu_data_oe, 1'b1);
        tick(1);
        chk1("rd_k13_cpuoe", bus.o_cpu_data_oe, 1'b1);
        tick(1);
        chk1("rd_k14_cpuoe", bus.o_cpu_data_oe, 1'b0);
        chk1("rd_k14_busy",  bus.o_busy,        1'b0);
        tick(2);

        // Write 0x0100 data 0x3C, window high 10 cycles
        bus.i_addr = 16'h0100; bus.i_rw = 1'b0; bus.i_cpu_data = 8'h3C;
        bus.i_sram_window = 1'b1;
        tick(1);
        chk1("wr_k_ce_n",    bus.o_sram_ce_n,    1'b0);
        chk1("wr_k_sramoe",  bus.o_sram_data_oe, 1'b1);
        chk1("wr_k_cpuoe",   bus.o_cpu_data_oe,  1'b0);
        chk1("wr_k_we_n",    bus.o_sram_we_n,    1'b1);
        tick(2);
        chk1("wr_k2_we_n",   bus.o_sram_we_n,    1'b1);
        tick(1);
        chk1("wr_k3_we_n",   bus.o_sram_we_n,    1'b0);
        chk1("wr_k3_oe_n",   bus.o_sram_oe_n,    1'b1);
        chk8("wr_k3_data",   bus.o_sram_data,    8'h3C);
        tick(6);
        bus.i_sram_window = 1'b0; bus.i_cpu_data = 8'hFF;
        tick(1);
        chk1("wr_k10_we_n",   bus.o_sram_we_n,    1'b1);
        chk1("wr_k10_ce_n",   bus.o_sram_ce_n,    1'b0);
        chk1("wr_k10_sramoe", bus.o_sram_data_oe, 1'b1);
        chk8("wr_k10_frozen", bus.o_sram_data,    8'h3C);
        chk1("wr_k10_err",    bus.o_err_short,    1'b0);
        tick(1);
        chk1("wr_k11_ce_n",   bus.o_sram_ce_n,    1'b1);
        chk1("wr_k11_sramoe", bus.o_sram_data_oe, 1'b0);
        chk1("wr_k11_busy",   bus.o_busy,         1'b0);
        tick(2);

        // Decode miss
        bus.i_addr = 16'h9000; bus.i_rw = 1'b1;
        bus.i_sram_window = 1'b1;
        tick(1);
        chk1("miss_busy",  bus.o_busy,        1'b1);
        chk1("miss_ce_n",  bus.o_sram_ce_n,   1'b1);
        chk1("miss_oe_n",  bus.o_sram_oe_n,   1'b1);
        tick(5);
        chk1("miss_cpuoe", bus.o_cpu_data_oe, 1'b0);
        chk1("miss_busy2", bus.o_busy,        1'b1);
        bus.i_sram_window = 1'b0;
        tick(1);
        chk1("miss_idle",  bus.o_busy,        1'b0);
        tick(2);

        // Short read window (3 cycles)
        bus.i_addr = 16'h0200; bus.i_rw = 1'b1; bus.i_sram_data = 8'h5A;
        bus.i_sram_window = 1'b1;
        tick(3);
        chk1("srd_k2_err", bus.o_err_short, 1'b0);
        bus.i_sram_window = 1'b0;
        tick(1);
        chk1("srd_k3_err",   bus.o_err_short,   1'b1);
        chk1("srd_k3_ce_n",  bus.o_sram_ce_n,   1'b1);
        chk1("srd_k3_cpuoe", bus.o_cpu_data_oe, 1'b0);
        tick(1);
        chk1("srd_k4_err",   bus.o_err_short,   1'b0);
        chk1("srd_k4_busy",  bus.o_busy,        1'b0);
        chk8("srd_nocap",    bus.o_cpu_data,    8'hA5);
        tick(2);

        // Short write window (2 cycles)
        bus.i_addr = 16'h0300; bus.i_rw = 1'b0; bus.i_cpu_data = 8'h11;
        bus.i_sram_window = 1'b1;
        tick(2);
        chk1("swr_k1_we_n", bus.o_sram_we_n, 1'b1);
        bus.i_sram_window = 1'b0;
        tick(1);
        chk1("swr_k2_err",  bus.o_err_short, 1'b1);
        chk1("swr_k2_we_n", bus.o_sram_we_n, 1'b1);
        tick(1);
        chk1("swr_k3_err",    bus.o_err_short,    1'b0);
        chk1("swr_k3_ce_n",   bus.o_sram_ce_n,    1'b1);
        chk1("swr_k3_sramoe", bus.o_sram_data_oe, 1'b0);
        tick(2);

        // Asynchronous reset in the middle of a write
        bus.i_addr = 16'h0400; bus.i_rw = 1'b0; bus.i_cpu_data = 8'h77;
        bus.i_sram_window = 1'b1;
        tick(6);
        chk1("arst_pre_we_n", bus.o_sram_we_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("arst_we_n",   bus.o_sram_we_n,    1'b1);
        chk1("arst_ce_n",   bus.o_sram_ce_n,    1'b1);
        chk1("arst_sramoe", bus.o_sram_data_oe, 1'b0);
        chk1("arst_busy",   bus.o_busy,         1'b0);
        chk8("arst_data",   bus.o_sram_data,    8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk1("arst_norise_ce_n", bus.o_sram_ce_n, 1'b1);
        chk1("arst_norise_busy", bus.o_busy,      1'b0);
        bus.i_sram_window = 1'b0;
        tick(1);
        bus.i_sram_window = 1'b1;
        tick(1);
        chk1("arst_rise_ce_n",   bus.o_sram_ce_n,    1'b0);
        chk1("arst_rise_sramoe", bus.o_sram_data_oe, 1'b1);
        bus.i_sram_window = 1'b0;
        tick(2);
        chk1("arst_end_busy", bus.o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_cycle_ctrl.md
Name: sram_cycle_ctrl

Overview:
- Downstream consumer of the E-clock delay stage. It takes the registered SRAM access window (the stretched, delayed SRAM enable produced on i_clk) plus the 6809 address and R/W.
- It runs one SRAM bus cycle per window: chip enable, output enable, write-strobe placement, read-data capture, and data-bus drive control toward CPU and SRAM.
- All outputs are registered on i_clk.

Parameters:
- SRAM_BASE, 16'h0000, decode base address.
- SRAM_MASK, 16'h8000, decode mask; hit when (i_addr & SRAM_MASK) == (SRAM_BASE & SRAM_MASK).
- RD_SETUP, 5, i_clk cycles from CE/OE assert to read-data capture (≥1).
- WR_DELAY, 3, i_clk cycles from CE assert to WE assert (≥1).
- HOLD, 2, i_clk cycles CPU-side read data stays driven after window drop (≥1).

Ports:
- i_clk  in  1  fast PLL clock, same domain as window source.
- i_reset  in  1  asynchronous, active-low reset.
- i_sram_window  in  1  SRAM access window, active high, synchronous to i_clk.
- i_rw  in  1  6809 R/W (1=read); sampled at window rise.
- i_addr  in  16  6809 address; sampled at window rise.
- i_cpu_data  in  8  CPU data bus (write data).
- i_sram_data  in  8  SRAM data bus (read data).
- o_cpu_data  out  8  captured read data to CPU bus.
- o_cpu_data_oe  out  1  FPGA drives CPU bus when 1.
- o_sram_data  out  8  write data to SRAM.
- o_sram_data_oe  out  1  FPGA drives SRAM bus when 1.
- o_sram_ce_n / o_sram_oe_n / o_sram_we_n  out  1 each  SRAM strobes, active low.
- o_busy  out  1  high in any state other than IDLE.
- o_err_short  out  1  one-cycle pulse when the window ends before the cycle completes.

Behaviour:
- Reset (async, i_reset=0):
  - All strobes go to 1; both data OEs and o_busy go to 0.
  - Data registers clear to 0; o_err_short clears to 0.
  - FSM enters IDLE; internal window_prev is set to 1, so a window already high at reset release does not start a cycle.
- Rise detection:
  - Rise = i_sram_window & ~window_prev.
  - Outputs update on the same edge that first samples the window high.
- States: IDLE, RD_ACCESS, RD_DRIVE, RD_HOLD, WR_ACTIVE, WR_HOLD, WAIT_LOW.
- IDLE:
  - Rise with decode hit and i_rw=1 → RD_ACCESS: ce_n=0, oe_n=0, cnt=RD_SETUP-1.
  - Rise with decode hit and i_rw=0 → WR_ACTIVE: ce_n=0, sram_data_oe=1, cnt=WR_DELAY-1.
  - Rise with no decode hit → WAIT_LOW; no strobes.
- RD_ACCESS:
  - Window high, cnt≠0 → decrement.
  - Window high, cnt==0 → o_cpu_data<=i_sram_data, cpu_data_oe=1, → RD_DRIVE. Capture happens at edge k+RD_SETUP.
  - Window low → ce_n=1, oe_n=1, err_short pulse, → IDLE; cpu_data_oe stays 0.
- RD_DRIVE:
  - Window sampled low → ce_n=1, oe_n=1, cnt=HOLD-1, → RD_HOLD.
- RD_HOLD:
  - Decrement each cycle; on cnt==0 → cpu_data_oe=0, → IDLE. cpu_data_oe therefore drops HOLD edges after window-low is sampled.
  - A new rise during RD_HOLD is ignored (cycle missed). It is not queued.
- WR_ACTIVE:
  - o_sram_data<=i_cpu_data every cycle.
  - cnt reaching 0 → we_n=0 at edge k+WR_DELAY.
  - Window sampled low → we_n=1 and o_sram_data frozen, ce_n stays 0, → WR_HOLD.
  - If we_n was never asserted, err_short pulses and no write occurs.
- WR_HOLD: next edge → ce_n=1, sram_data_oe=0, → IDLE.
- WAIT_LOW: window low → IDLE.
- Invariants:
  - sram_data_oe and cpu_data_oe are never 1 simultaneously.
  - we_n=0 only when ce_n=0 and oe_n=1.
- Counters are sized to the largest parameter; no wrap occurs because every counter is reloaded on entry to its state.

Test Plan (defaults; window rise sampled at edge k):
- Read 0x1234, window high 12 cycles, i_sram_data=0xA5 → ce_n/oe_n low at k; o_cpu_data=0xA5 and cpu_data_oe=1 at k+5; strobes high at k+12; cpu_data_oe low at k+14.
- Write 0x0100, i_cpu_data=0x3C, window 10 cycles → sram_data_oe and ce_n asserted at k; we_n low at k+3, high at k+10; o_sram_data=0x3C; ce_n high and sram_data_oe low at k+11.
- Read 0x9000 (decode miss) → no strobe or OE activity, o_busy=1 until window low, then IDLE.
- Short read window (3 cycles) → no data capture; cpu_data_oe never 1; err_short one pulse at k+3.
- Short write window (2 cycles) → we_n stays 1; err_short pulses.
- i_reset low mid-write at k+5 (WE asserted) → all strobes high and OEs low immediately (asynchronous). After release with window still high, no cycle starts until the next rise.
